// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller: load-use and HI/LO hazard stalls, branch flushes,
// MUL/DIV occupancy tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_md_op,
  input  logic             id_hilo_rd,
  input  logic             ex_memread,
  input  logic [4:0]       ex_wn,
  input  logic             branch_taken,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_bubble,
  output logic             md_start,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {IDLE, BUSY} md_state_t;

  md_state_t  state, state_nxt;
  logic [7:0] md_cnt, md_cnt_nxt;
  logic       lu, mdh;

  // ex_memread gates the whole term so an unused ex_wn can never create a stall.
  assign lu = ex_memread && (ex_wn != 5'd0) &&
              ((id_use_rs && (id_rs == ex_wn)) || (id_use_rt && (id_rt == ex_wn)));

  assign md_busy  = (state == BUSY);
  assign md_done  = md_busy && (md_cnt == 8'd0);
  assign mdh      = md_busy && (id_md_op || id_hilo_rd);
  assign md_start = id_md_op && !md_busy && !lu && !branch_taken;

  // NOTE: every output gets a default before the priority chain, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    pc_we       = 1'b1;
    ifid_we     = 1'b1;
    ifid_flush  = 1'b0;
    idex_bubble = 1'b0;
    if (branch_taken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (lu || mdh) begin
      pc_we       = 1'b0;
      ifid_we     = 1'b0;
      idex_bubble = 1'b1;
    end
  end

  always_comb begin
    state_nxt  = state;
    md_cnt_nxt = md_cnt;
    case (state)
      IDLE: begin
        if (md_start) begin
          state_nxt  = BUSY;
          md_cnt_nxt = 8'(MD_LAT - 1);
        end
      end
      BUSY: begin
        if (md_cnt == 8'd0) state_nxt  = IDLE;
        else                md_cnt_nxt = md_cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      md_cnt    <= 8'd0;
      stall_cnt <= '0;
    end else begin
      state  <= state_nxt;
      md_cnt <= md_cnt_nxt;
      if (!pc_we && (stall_cnt != {CNT_W{1'b1}}))
        stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a timeline model (operation start cycle, stall tally)
// checked against the DUT every cycle, plus hand-computed literal expectations.
module tb_hazard_ctrl;

  localparam int MD_LAT = 4;
  localparam int CNT_W  = 16;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [4:0]       id_rs, id_rt, ex_wn;
  logic             id_use_rs, id_use_rt, id_md_op, id_hilo_rd, ex_memread, branch_taken;
  logic             pc_we, ifid_we, ifid_flush, idex_bubble, md_start, md_busy, md_done;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_md_op(id_md_op), .id_hilo_rd(id_hilo_rd),
    .ex_memread(ex_memread), .ex_wn(ex_wn), .branch_taken(branch_taken),
    .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush), .idex_bubble(idex_bubble),
    .md_start(md_start), .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state: an operation started in cycle t0 is busy in cycles t0+1..t0+MD_LAT
  // and done in cycle t0+MD_LAT. Stalls are a plain clamped integer tally.
  typedef struct packed {
    logic pc_we, ifid_we, flush, bubble, start, busy, done;
  } exp_t;

  longint cyc    = 0;
  longint t0     = 0;
  bit     op_vld = 1'b0;
  int     stalls = 0;
  bit     chk_en = 1'b0;

  function automatic exp_t model();
    exp_t e;
    bit   lu_m, hz;
    e.busy  = op_vld && (cyc > t0) && (cyc <= t0 + MD_LAT);
    e.done  = op_vld && (cyc == t0 + MD_LAT);
    lu_m    = ex_memread && (ex_wn != 0) &&
              ((id_use_rs && id_rs == ex_wn) || (id_use_rt && id_rt == ex_wn));
    hz      = lu_m || (e.busy && (id_md_op || id_hilo_rd));
    e.flush  = branch_taken;
    e.bubble = branch_taken || hz;
    e.pc_we  = branch_taken || !hz;
    e.ifid_we = e.pc_we;
    e.start  = id_md_op && !e.busy && !lu_m && !branch_taken;
    return e;
  endfunction

  always @(posedge clk) begin
    exp_t e;
    e = model();
    if (rst) begin
      op_vld <= 1'b0;
      stalls <= 0;
    end else begin
      if (e.start) begin
        op_vld <= 1'b1;
        t0     <= cyc;
      end
      if (!e.pc_we && stalls < CMAX) stalls <= stalls + 1;
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      e = model();
      check("pc_we",       32'(pc_we),       32'(e.pc_we));
      check("ifid_we",     32'(ifid_we),     32'(e.ifid_we));
      check("ifid_flush",  32'(ifid_flush),  32'(e.flush));
      check("idex_bubble", 32'(idex_bubble), 32'(e.bubble));
      check("md_start",    32'(md_start),    32'(e.start));
      check("md_busy",     32'(md_busy),     32'(e.busy));
      check("md_done",     32'(md_done),     32'(e.done));
      check("stall_cnt",   32'(stall_cnt),   32'(stalls));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0; id_md_op = 0;
    id_hilo_rd = 0; ex_memread = 0; ex_wn = 0; branch_taken = 0;
  endtask

  task automatic set_lu8();
    ex_memread = 1; ex_wn = 5'd8; id_use_rs = 1; id_rs = 5'd8;
  endtask

  initial begin
    int starts;
    logic [CNT_W-1:0] snap;
    idle_in();
    rst = 1;
    tick();
    chk_en = 1'b1;
    tick();
    rst = 0;
    #1;
    check("rst_pc_we", 32'(pc_we), 32'd1);
    check("rst_ifid_we", 32'(ifid_we), 32'd1);
    check("rst_busy", 32'(md_busy), 32'd0);
    check("rst_done", 32'(md_done), 32'd0);
    check("rst_cnt", 32'(stall_cnt), 32'd0);

    // Load-use on rs: one stall cycle, then the load moves on.
    tick();
    set_lu8();
    #1;
    check("lu_pc_we", 32'(pc_we), 32'd0);
    check("lu_ifid_we", 32'(ifid_we), 32'd0);
    check("lu_bubble", 32'(idex_bubble), 32'd1);
    tick();
    ex_memread = 0;
    #1;
    check("lu_release", 32'(pc_we), 32'd1);
    check("lu_cnt", 32'(stall_cnt), 32'd1);

    // $0 and non-load cases never stall; rt path does.
    tick();
    ex_memread = 1; ex_wn = 0; id_rs = 0;
    #1 check("r0_no_stall", 32'(pc_we), 32'd1);
    tick();
    ex_memread = 0; ex_wn = 5'd8; id_rs = 5'd8;
    #1 check("noload_no_stall", 32'(pc_we), 32'd1);
    tick();
    ex_memread = 1; id_use_rs = 0; id_use_rt = 1; id_rt = 5'd8;
    #1 check("lu_rt_stall", 32'(pc_we), 32'd0);
    tick();
    id_use_rt = 0;
    #1 check("rt_unused", 32'(pc_we), 32'd1);

    // Load-use coincident with a taken branch: flush wins, no stall counted.
    tick();
    set_lu8();
    branch_taken = 1;
    snap = stall_cnt;
    #1;
    check("br_flush", 32'(ifid_flush), 32'd1);
    check("br_bubble", 32'(idex_bubble), 32'd1);
    check("br_pc_we", 32'(pc_we), 32'd1);
    tick();
    idle_in();
    #1 check("br_cnt_hold", 32'(stall_cnt), 32'(snap));

    // MULT then MFLO held in ID: busy 1..4, done at 4, MFLO issues at 5.
    tick();
    id_md_op = 1;
    #1 check("md_start0", 32'(md_start), 32'd1);
    tick();
    id_md_op = 0; id_hilo_rd = 1;
    for (int k = 1; k <= MD_LAT; k++) begin
      #1;
      check("mflo_busy", 32'(md_busy), 32'd1);
      check("mflo_stall", 32'(pc_we), 32'd0);
      check("mflo_done", 32'(md_done), 32'(k == MD_LAT));
      tick();
    end
    #1;
    check("mflo_issue", 32'(pc_we), 32'd1);
    check("mflo_idle", 32'(md_busy), 32'd0);
    tick();
    id_hilo_rd = 0;

    // Second MULT arriving during BUSY stalls, then starts exactly once.
    id_md_op = 1;
    tick();
    starts = 0;
    for (int k = 1; k <= MD_LAT + 1; k++) begin
      #1;
      if (md_start) starts++;
      if (k <= MD_LAT) check("md2_stall", 32'(pc_we), 32'd0);
      else             check("md2_start", 32'(md_start), 32'd1);
      tick();
    end
    id_md_op = 0;
    check("md2_once", 32'(starts), 32'd1);
    repeat (MD_LAT + 2) tick();

    // Taken branch during BUSY does not abort the operation.
    id_md_op = 1;
    tick();
    id_md_op = 0; branch_taken = 1;
    tick();
    branch_taken = 0;
    tick();
    tick();
    #1 check("br_busy_done", 32'(md_done), 32'd1);
    tick();

    // Reset in the second BUSY cycle kills the operation without md_done.
    id_md_op = 1;
    tick();
    id_md_op = 0;
    tick();
    rst = 1;
    #1 check("rst_mid_busy", 32'(md_busy), 32'd1);
    tick();
    rst = 0;
    #1;
    check("rst_mid_idle", 32'(md_busy), 32'd0);
    check("rst_mid_cnt", 32'(stall_cnt), 32'd0);
    for (int k = 0; k < MD_LAT + 2; k++) begin
      #1 check("rst_no_done", 32'(md_done), 32'd0);
      tick();
    end

    // Long load-use stall drives the counter into saturation.
    set_lu8();
    repeat (CMAX + 4) tick();
    #1 check("sat_max", 32'(stall_cnt), 32'hFFFF);
    tick();
    #1 check("sat_hold", 32'(stall_cnt), 32'hFFFF);
    idle_in();
    #1 check("sat_release", 32'(pc_we), 32'd1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
